// File: rtl/prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_queue_pkg
// Shared types for the instruction prefetch queue.
//   XLEN          : architectural word / address width (32)
//   inst_word_t   : one instruction word
//   queue_entry_t : one queue slot, {pc, inst}
//   align_pc()    : clears the two low bits of a fetch address
// -----------------------------------------------------------------------------
package prefetch_queue_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] inst_word_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        inst_word_t      inst;
    } queue_entry_t;

    // Masking (rather than slicing) keeps every bit of the operand in use.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/prefetch_queue_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the prefetch queue storage.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset (pointers and count only)
//   flush_i      : empties the FIFO; wins over push and pop in the same cycle
//   push_i       : write push_data_i at the tail
//   push_data_i  : WIDTH-bit entry
//   pop_i        : drop the head entry
//   head_data_o  : current head entry (valid when cnt_o != 0)
//   cnt_o        : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by cnt_q, so
    // stale contents are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
// Instruction prefetcher: issues sequential fetches, tracks in-flight requests
// with a credit scheme so the queue can never overflow, and discards responses
// belonging to fetches made before a redirect.
//   clk_i, rst_i       : clock (rising edge), async active-high reset
//   redirect_i         : branch/jump strobe; redirect_pc_i is the new target
//   req_valid_o/addr_o : fetch request toward memory, accepted by req_ready_i
//   rsp_valid_i/data_i : in-order instruction words from memory
//   inst_valid_o/inst_o/inst_pc_o : queue head toward decode, taken by inst_ready_i
//   perf_empty_cnt_o   : only when PREFETCH_QUEUE_PERF_EN is defined; counts
//                        cycles decode was ready but the queue was empty
// -----------------------------------------------------------------------------
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            req_ready_i,
    input  logic            rsp_valid_i,
    input  inst_word_t      rsp_data_i,
    output logic            inst_valid_o,
    output inst_word_t      inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
`ifdef PREFETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     perf_empty_cnt_o
`endif
);

    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  rsp_pc_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] out_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             rsp_accept;
    logic             rsp_keep;
    logic             inst_pop;
    queue_entry_t     push_entry;
    queue_entry_t     head_entry;

    // Words in the queue plus words still in flight must fit in the queue,
    // so every kept response is guaranteed a free slot on arrival.
    assign credit_used = {1'b0, cnt} + {1'b0, out_cnt_q};
    assign req_valid_o = !rst_i && !redirect_i
                         && (out_cnt_q < MAX_OUT_C)
                         && (credit_used < {1'b0, DEPTH_C});
    assign req_addr_o  = pc_q;
    assign req_fire    = req_valid_o && req_ready_i;

    // A response with nothing in flight is spurious and ignored entirely.
    assign rsp_accept  = rsp_valid_i && (out_cnt_q != '0);
    // Stale words (drop_cnt_q > 0) and a word arriving with a redirect are discarded.
    assign rsp_keep    = rsp_accept && (drop_cnt_q == '0) && !redirect_i;

    assign inst_valid_o = (cnt != '0);
    assign inst_pop     = inst_valid_o && inst_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_accept);
            if (redirect_i) begin
                pc_q       <= align_pc(redirect_pc_i);
                rsp_pc_q   <= align_pc(redirect_pc_i);
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt_q <= out_cnt_q - CNT_W'(rsp_accept);
            end else begin
                if (req_fire)                         pc_q       <= pc_q + 32'd4;
                if (rsp_keep)                         rsp_pc_q   <= rsp_pc_q + 32'd4;
                if (rsp_accept && drop_cnt_q != '0)   drop_cnt_q <= drop_cnt_q - CNT_W'(1);
            end
        end
    end

    assign push_entry = '{pc: rsp_pc_q, inst: rsp_data_i};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(queue_entry_t))
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (inst_pop),
        .head_data_o (head_entry),
        .cnt_o       (cnt)
    );

    assign inst_o    = head_entry.inst;
    assign inst_pc_o = head_entry.pc;

`ifdef PREFETCH_QUEUE_PERF_EN
    logic [31:0] perf_empty_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_empty_cnt_q <= '0;
        end else if (inst_ready_i && !inst_valid_o && (perf_empty_cnt_q != '1)) begin
            perf_empty_cnt_q <= perf_empty_cnt_q + 32'd1;
        end
    end

    assign perf_empty_cnt_o = perf_empty_cnt_q;
`else
    // Starvation counter not built in this configuration.
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
// Directed bench for prefetch_queue (DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0).
// A memory model returns in-order responses one cycle after acceptance and
// grants only as many requests as the current test budgets. Each test pushes
// the instruction addresses it expects decode to see into exp_q; an
// independent monitor pops and compares on every decode handshake.
// Inputs change on the falling edge; outputs are sampled a few ns later.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i = 1'b0;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;
`ifdef PREFETCH_QUEUE_PERF_EN
    logic [31:0] perf_empty_cnt_o;
`endif

    prefetch_queue dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .req_valid_o   (req_valid_o),
        .req_addr_o    (req_addr_o),
        .req_ready_i   (req_ready_i),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_data_i    (rsp_data_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
`ifdef PREFETCH_QUEUE_PERF_EN
        ,
        .perf_empty_cnt_o (perf_empty_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          budget  = 0;     // requests the memory may still accept
    logic        rsp_en  = 1'b0;  // memory returns pending words when set
    logic        spurious = 1'b0; // inject a response with nothing in flight
    logic [31:0] exp_q   [$];     // expected instruction addresses at decode
    logic [31:0] pending [$];     // accepted, not yet answered
    logic [31:0] issued  [$];     // every accepted request address

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check_issued(input string name, input int n, input logic [31:0] e [5]);
        check({name, "_count"}, 32'(issued.size()), 32'(n));
        for (int i = 0; i < n && i < issued.size(); i++)
            check({name, "_addr"}, issued[i], e[i]);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        budget       = 0;
        rsp_en       = 1'b0;
        spurious     = 1'b0;
        inst_ready_i = 1'b0;
        redirect_i   = 1'b0;
        cycles(2);
        #1;
        check("rst_req_valid", 32'(req_valid_o), 0);
        check("rst_inst_valid", 32'(inst_valid_o), 0);
        exp_q.delete();
        issued.delete();
        cycles(1);
        rst_i = 1'b0;
        #1;
        check("rst_req_addr", req_addr_o, 32'h0);
    endtask

    // Memory model: 1-cycle in-order responses, grants limited by budget.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                pending.delete();
                rsp_valid_i = 1'b0;
                req_ready_i = 1'b0;
            end else begin
                rsp_valid_i = spurious || (rsp_en && pending.size() > 0);
                rsp_data_i  = (rsp_en && pending.size() > 0) ? mem_word(pending[0]) : 32'hBAD0_BAD0;
                req_ready_i = (budget > 0);
                #1;
                if (rsp_en && pending.size() > 0) void'(pending.pop_front());
                if (req_valid_o && req_ready_i) begin
                    pending.push_back(req_addr_o);
                    issued.push_back(req_addr_o);
                    budget--;
                end
            end
        end
    end

    // Decode-side monitor: compares every consumed head with the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            #3;
            if (!rst_i && inst_valid_o && inst_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc %h, expected no instruction", inst_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc_o, e);
                    check("inst_data", inst_o, mem_word(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Sequential fetch with an always-ready memory.
        do_reset();
        inst_ready_i = 1'b1;
        rsp_en = 1'b1;
        budget = 3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        cycles(10);
        #1;
        check("t1_drain", 32'(exp_q.size()), 0);
        check_issued("t1_issued", 3, '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0});
        check("t1_next_addr", req_addr_o, 32'hC);
        check("t1_empty", 32'(inst_valid_o), 0);

        // Decode stalled: credits stop fetching at exactly DEPTH words.
        do_reset();
        rsp_en = 1'b1;
        budget = 5;
        cycles(20);
        #1;
        check("t2_issued_count", 32'(issued.size()), 4);
        check("t2_req_blocked", 32'(req_valid_o), 0);
        check("t2_head_valid", 32'(inst_valid_o), 1);
        check("t2_head_pc", inst_pc_o, 32'h0);
        cycles(1);
        exp_q.push_back(32'h0);
        inst_ready_i = 1'b1;
        cycles(1);
        inst_ready_i = 1'b0;
        #1;
        check("t2_req_after_pop", 32'(req_valid_o), 1);
        check("t2_addr_after_pop", req_addr_o, 32'h10);
        cycles(4);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        inst_ready_i = 1'b1;
        cycles(10);
        #1;
        check("t2_drain", 32'(exp_q.size()), 0);
        check_issued("t2_issued", 5, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10});
        check("t2_next_addr", req_addr_o, 32'h14);

        // Redirect to an unaligned target with two fetches in flight.
        do_reset();
        inst_ready_i = 1'b1;
        budget = 2;
        cycles(4);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        budget = 2;
        #1;
        check("t3_no_req_in_redirect", 32'(req_valid_o), 0);
        cycles(1);
        redirect_i = 1'b0;
        rsp_en = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        #1;
        check("t3_redirect_addr", req_addr_o, 32'h100);
        cycles(12);
        #1;
        check("t3_drain", 32'(exp_q.size()), 0);
        check_issued("t3_issued", 4, '{32'h0, 32'h4, 32'h100, 32'h104, 32'h0});

        // Response arriving in the redirect cycle is discarded; queue flushes.
        do_reset();
        rsp_en = 1'b1;
        budget = 1;
        cycles(4);
        rsp_en = 1'b0;
        budget = 2;
        cycles(4);
        #1;
        check("t4_pre_valid", 32'(inst_valid_o), 1);
        cycles(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        rsp_en = 1'b1;
        budget = 2;
        cycles(1);
        redirect_i = 1'b0;
        inst_ready_i = 1'b1;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        #1;
        check("t4_flushed", 32'(inst_valid_o), 0);
        cycles(12);
        #1;
        check("t4_drain", 32'(exp_q.size()), 0);
        check_issued("t4_issued", 5, '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204});

        // Push and pop together on a loaded queue; spurious response ignored.
        do_reset();
        rsp_en = 1'b1;
        budget = 3;
        cycles(8);
        rsp_en = 1'b0;
        budget = 1;
        cycles(3);
        #1;
        check("t5_credit_full", 32'(req_valid_o), 0);
        cycles(1);
        rsp_en = 1'b1;
        inst_ready_i = 1'b1;
        exp_q.push_back(32'h0);
        cycles(1);
        rsp_en = 1'b0;
        inst_ready_i = 1'b0;
        #1;
        check("t5_head_after_pushpop", inst_pc_o, 32'h4);
        cycles(1);
        spurious = 1'b1;
        cycles(1);
        spurious = 1'b0;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        inst_ready_i = 1'b1;
        cycles(8);
        #1;
        check("t5_drain", 32'(exp_q.size()), 0);
        check("t5_empty", 32'(inst_valid_o), 0);

`ifdef PREFETCH_QUEUE_PERF_EN
        // Starvation counter: five empty-and-ready cycles, then reset mid-run.
        do_reset();
        inst_ready_i = 1'b1;
        cycles(5);
        inst_ready_i = 1'b0;
        #1;
        check("perf_count", perf_empty_cnt_o, 32'd5);
        cycles(1);
        inst_ready_i = 1'b1;
        cycles(3);
        rst_i = 1'b1;
        #1;
        check("perf_reset", perf_empty_cnt_o, 32'd0);
        cycles(1);
        rst_i = 1'b0;
        inst_ready_i = 1'b0;
`endif

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
